// File: rtl/snd_clk_pkg.sv
// snd_clk_pkg: shared types and helpers for the sound serial-clock generator.
//   state_t     - generator FSM states
//   RATE_W      - width of the rate selector
//   SLOT_IDX_W  - width of the slot index output
//   BIT_IDX_W   - width of the bit index output
//   HC_W        - width of the half-period counter (covers 2^7)
//   clamp_rate  - limits a requested rate to the largest legal value
package snd_clk_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUTE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam int unsigned RATE_W     = 3;
  localparam int unsigned SLOT_IDX_W = 4;
  localparam int unsigned BIT_IDX_W  = 5;
  localparam int unsigned HC_W       = 8;

  function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] sel,
                                                    input logic [RATE_W-1:0] max_rate);
    return (sel > max_rate) ? max_rate : sel;
  endfunction

endpackage

// File: rtl/snd_pow2_div.sv
// snd_pow2_div: power-of-two BCLK divider with registered edge strobes.
//   clk      in   master clock
//   rst      in   synchronous reset, active-high (also loads rate_in)
//   clear    in   hold counter, BCLK and strobes at 0
//   load     in   latch rate_in and restart from 0
//   rate_in  in   half period = 2^rate_in clk cycles
//   bclk     out  divided clock
//   rise     out  strobe coincident with bclk 0->1
//   fall     out  strobe coincident with bclk 1->0
//   tick     out  counter is at its last half-period cycle (next edge toggles)
module snd_pow2_div
  import snd_clk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [RATE_W-1:0] rate_in,
  output logic              bclk,
  output logic              rise,
  output logic              fall,
  output logic              tick
);

  logic [HC_W-1:0]   hc;
  logic [HC_W-1:0]   hc_last;
  logic [RATE_W-1:0] rate;

  assign hc_last = (HC_W'(1) << rate) - HC_W'(1);
  assign tick    = (hc == hc_last);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      hc   <= '0;
      bclk <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      rate <= rate_in;
    end else if (clear) begin
      hc   <= '0;
      bclk <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        hc   <= '0;
        bclk <= ~bclk;
        rise <= ~bclk;
        fall <= bclk;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snd_clkgen_tdm.sv
// snd_clkgen_tdm: audio BCLK/LRCK generator for I2S/TDM (PCM) and DSD.
//   SND_MCLK     in   master clock, all logic on rising edge
//   RST          in   synchronous reset, active-high
//   RATE_SEL     in   BCLK = SND_MCLK / 2^(RATE_SEL+1), clamped to RATE_MAX
//   DSD_MODE     in   1 = DSD (LRCK and SLOT_IDX held 0)
//   BCLK, LRCK   out  serial clocks
//   BCLK_RISE    out  strobe with BCLK 0->1
//   BCLK_FALL    out  strobe with BCLK 1->0
//   FRAME_START  out  strobe on the fall that begins slot 0 bit 0
//   SLOT_IDX     out  current slot
//   BIT_IDX      out  current bit within the slot (MSB first, from 0)
//   LOCKED       out  high only while running at the requested rate/mode
// Build option: SND_CLKGEN_I2S_DELAY_EN delays PCM LRCK by one BCLK (Philips I2S).
module snd_clkgen_tdm
  import snd_clk_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned MUTE_CYC = 1024,
  parameter int unsigned RATE_MAX = 5
) (
  input  logic       SND_MCLK,
  input  logic       RST,
  input  logic [2:0] RATE_SEL,
  input  logic       DSD_MODE,
  output logic       BCLK,
  output logic       LRCK,
  output logic       BCLK_RISE,
  output logic       BCLK_FALL,
  output logic       FRAME_START,
  output logic [3:0] SLOT_IDX,
  output logic [4:0] BIT_IDX,
  output logic       LOCKED
);

  localparam int unsigned MC_W = (MUTE_CYC > 1) ? $clog2(MUTE_CYC) : 1;
  localparam logic [MC_W-1:0]       MC_LAST   = MC_W'(MUTE_CYC - 1);
  localparam logic [BIT_IDX_W-1:0]  BIT_LAST  = BIT_IDX_W'(SLOT_W - 1);
  localparam logic [SLOT_IDX_W-1:0] SLOT_LAST = SLOT_IDX_W'(NUM_CH - 1);
  localparam logic [SLOT_IDX_W-1:0] SLOT_HALF = SLOT_IDX_W'(NUM_CH / 2);

  state_t                  state, state_next;
  logic [MC_W-1:0]         mute_cnt;
  logic [RATE_W-1:0]       act_rate, req_rate;
  logic                    act_dsd;
  logic                    changed, latch;
  logic                    div_bclk, div_rise, div_fall, div_tick;
  logic                    fall_due, run_ok, fall_now, frame_end;
  logic                    started, lrck, lrck_nxt, frame_start, locked;
  logic [SLOT_IDX_W-1:0]   slot_idx, slot_nxt;
  logic [BIT_IDX_W-1:0]    bit_idx;

  assign req_rate = clamp_rate(RATE_SEL, RATE_W'(RATE_MAX));
  assign changed  = (req_rate != act_rate) || (DSD_MODE != act_dsd);
  assign fall_due = div_tick && div_bclk;
  // The very first fall after entering RUN is itself a frame boundary, so a
  // drain requested before it can end there without emitting a partial frame.
  assign frame_end = !started ||
                     ((bit_idx == BIT_LAST) && (act_dsd || (slot_idx == SLOT_LAST)));

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    case (state)
      S_IDLE: begin
        state_next = S_MUTE;
        latch      = 1'b1;
      end
      S_MUTE: begin
        if (changed) begin
          latch = 1'b1;
        end else if (mute_cnt == MC_LAST) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (changed) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fall_due && frame_end) begin
          state_next = S_MUTE;
          latch      = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge SND_MCLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge SND_MCLK) begin
    if (RST) begin
      mute_cnt <= '0;
      act_rate <= req_rate;
      act_dsd  <= DSD_MODE;
      locked   <= 1'b0;
    end else begin
      locked <= (state_next == S_RUN);
      if (latch) begin
        act_rate <= req_rate;
        act_dsd  <= DSD_MODE;
        mute_cnt <= '0;
      end else if (state == S_MUTE) begin
        mute_cnt <= mute_cnt + 1'b1;
      end
    end
  end

  // Divider only counts while staying in RUN/DRAIN; the entry cycle keeps it
  // cleared so the first rise lands exactly 2^rate cycles after entry.
  assign run_ok = ((state == S_RUN) || (state == S_DRAIN)) &&
                  ((state_next == S_RUN) || (state_next == S_DRAIN));
  assign fall_now = fall_due && run_ok;

  snd_pow2_div u_div (
    .clk     (SND_MCLK),
    .rst     (RST),
    .clear   (!run_ok),
    .load    (latch),
    .rate_in (req_rate),
    .bclk    (div_bclk),
    .rise    (div_rise),
    .fall    (div_fall),
    .tick    (div_tick)
  );

  always_comb begin
    slot_nxt = slot_idx;
    if (fall_now && started && (bit_idx == BIT_LAST)) begin
      slot_nxt = (act_dsd || (slot_idx == SLOT_LAST)) ? '0 : slot_idx + 1'b1;
    end
    if (act_dsd) begin
      lrck_nxt = 1'b0;
    end else begin
`ifdef SND_CLKGEN_I2S_DELAY_EN
      // Using the slot just finished delays LRCK by one BCLK period.
      lrck_nxt = (slot_idx >= SLOT_HALF);
`else
      lrck_nxt = (slot_nxt >= SLOT_HALF);
`endif
    end
  end

  always_ff @(posedge SND_MCLK) begin
    if (RST || !run_ok) begin
      slot_idx    <= '0;
      bit_idx     <= '0;
      lrck        <= 1'b0;
      frame_start <= 1'b0;
      started     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (fall_now) begin
        slot_idx <= slot_nxt;
        lrck     <= lrck_nxt;
        if (!started) begin
          started     <= 1'b1;
          frame_start <= 1'b1;
        end else if (bit_idx == BIT_LAST) begin
          bit_idx     <= '0;
          frame_start <= act_dsd || (slot_idx == SLOT_LAST);
        end else begin
          bit_idx <= bit_idx + 1'b1;
        end
      end
    end
  end

  assign BCLK        = div_bclk;
  assign BCLK_RISE   = div_rise;
  assign BCLK_FALL   = div_fall;
  assign LRCK        = lrck;
  assign FRAME_START = frame_start;
  assign SLOT_IDX    = slot_idx;
  assign BIT_IDX     = bit_idx;
  assign LOCKED      = locked;

endmodule

// File: tb/tb_snd_clkgen_tdm.sv
module tb_snd_clkgen_tdm;

  localparam int NCH1 = 2, SW1 = 32, MC1 = 16, RMAX = 5;
  localparam int NCH2 = 8, SW2 = 16, MC2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b1, dsd1 = 1'b0;
  logic [2:0] rate1 = 3'd2;
  logic       bclk1, lrck1, rise1, fall1, fs1, locked1;
  logic [3:0] slot1;
  logic [4:0] bit1;

  logic       rst2 = 1'b1, dsd2 = 1'b0;
  logic [2:0] rate2 = 3'd0;
  logic       bclk2, lrck2, rise2, fall2, fs2, locked2;
  logic [3:0] slot2;
  logic [4:0] bit2;

  int total = 0;
  int bad = 0;

  snd_clkgen_tdm #(.NUM_CH(NCH1), .SLOT_W(SW1), .MUTE_CYC(MC1), .RATE_MAX(RMAX)) dut1 (
    .SND_MCLK(clk), .RST(rst1), .RATE_SEL(rate1), .DSD_MODE(dsd1),
    .BCLK(bclk1), .LRCK(lrck1), .BCLK_RISE(rise1), .BCLK_FALL(fall1),
    .FRAME_START(fs1), .SLOT_IDX(slot1), .BIT_IDX(bit1), .LOCKED(locked1));

  snd_clkgen_tdm #(.NUM_CH(NCH2), .SLOT_W(SW2), .MUTE_CYC(MC2), .RATE_MAX(RMAX)) dut2 (
    .SND_MCLK(clk), .RST(rst2), .RATE_SEL(rate2), .DSD_MODE(dsd2),
    .BCLK(bclk2), .LRCK(lrck2), .BCLK_RISE(rise2), .BCLK_FALL(fall2),
    .FRAME_START(fs2), .SLOT_IDX(slot2), .BIT_IDX(bit2), .LOCKED(locked2));

  // Reference model for dut1: timing derived from cycles elapsed since RUN entry.
  int ph = 0, m_cnt = 0, m_rate = 0, m_n = 0;
  bit m_dsd = 1'b0;
  logic       e_bclk = 0, e_lrck = 0, e_rise = 0, e_fall = 0, e_fs = 0, e_locked = 0;
  logic [3:0] e_slot = '0;
  logic [4:0] e_bit = '0;
  logic [14:0] obs1, exp1, obs2;
  assign obs1 = {bclk1, lrck1, rise1, fall1, fs1, slot1, bit1, locked1};
  assign exp1 = {e_bclk, e_lrck, e_rise, e_fall, e_fs, e_slot, e_bit, e_locked};
  assign obs2 = {bclk2, lrck2, rise2, fall2, fs2, slot2, bit2, locked2};

  function automatic bit fs_at(int n, int r, bit d);
    int p;
    p = 2 << r;
    if (n <= 0 || (n % p) != 0) return 1'b0;
    return ((n / p - 1) % (d ? SW1 : SW1 * NCH1)) == 0;
  endfunction

  always @(posedge clk) begin
    int cr, h, p, k, b;
    cr = (int'(rate1) > RMAX) ? RMAX : int'(rate1);
    if (rst1) begin
      ph = 0; m_rate = cr; m_dsd = dsd1;
    end else begin
      case (ph)
        0: begin ph = 1; m_rate = cr; m_dsd = dsd1; m_cnt = 1; end
        1: begin
          if (cr != m_rate || dsd1 != m_dsd) begin m_rate = cr; m_dsd = dsd1; m_cnt = 1; end
          else if (m_cnt == MC1) begin ph = 2; m_n = 0; end
          else m_cnt++;
        end
        2: begin if (cr != m_rate || dsd1 != m_dsd) ph = 3; m_n++; end
        default: begin
          m_n++;
          if (fs_at(m_n, m_rate, m_dsd)) begin ph = 1; m_rate = cr; m_dsd = dsd1; m_cnt = 1; end
        end
      endcase
    end
    if (ph >= 2) begin
      h = 1 << m_rate; p = 2 * h; k = m_n / p; b = (k > 0) ? k - 1 : 0;
      e_bclk = ((m_n / h) % 2) == 1;
      e_rise = (m_n % p) == h;
      e_fall = (m_n > 0) && ((m_n % p) == 0);
      e_bit = 5'(b % SW1);
      e_slot = m_dsd ? 4'd0 : 4'((b / SW1) % NCH1);
      e_fs = fs_at(m_n, m_rate, m_dsd);
`ifdef SND_CLKGEN_I2S_DELAY_EN
      e_lrck = (!m_dsd && k >= 2) ? (((b - 1) / SW1) % NCH1 >= NCH1 / 2) : 1'b0;
`else
      e_lrck = !m_dsd && (int'(e_slot) >= NCH1 / 2);
`endif
      e_locked = (ph == 2);
    end else begin
      {e_bclk, e_lrck, e_rise, e_fall, e_fs, e_slot, e_bit, e_locked} = '0;
    end
  end

  task automatic test_reset;
    int n, c, hi;
    bit seen;
    rst1 = 1'b1; rate1 = 3'd2; dsd1 = 1'b0;
    repeat (4) begin
      @(negedge clk); total++;
      if (obs1 !== 15'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", obs1); end
    end
    rst1 = 1'b0;
    n = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); n++; total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL reset_model: got %h want %h", obs1, exp1); end
      if (locked1) begin seen = 1; break; end
    end
    total++;
    if (!seen || n != MC1 + 1) begin bad++; $display("FAIL lock_latency: got %0d want %0d", n, MC1 + 1); end
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL period_model: got %h want %h", obs1, exp1); end
      seen = rise1;
    end
    c = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); c++; total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL period_model: got %h want %h", obs1, exp1); end
      if (rise1) break;
    end
    total++;
    if (!seen || c != 8) begin bad++; $display("FAIL bclk_period: got %0d want 8", c); end
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk); total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL frame_model: got %h want %h", obs1, exp1); end
      seen = fs1;
    end
    c = 0; hi = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); c++; total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL frame_model: got %h want %h", obs1, exp1); end
      if (lrck1) hi++;
      if (fs1) break;
    end
    total++;
    if (!seen || c != 512) begin bad++; $display("FAIL frame_period: got %0d want 512", c); end
    total++;
    if (hi != 256) begin bad++; $display("FAIL lrck_high: got %0d want 256", hi); end
  endtask

  task automatic test_rate0;
    bit seen, prev_rise;
    rate1 = 3'd0;
    @(negedge clk); total++;
    if (locked1 !== 1'b0) begin bad++; $display("FAIL rate0_unlock: got %b want 0", locked1); end
    seen = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk); total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL rate0_model: got %h want %h", obs1, exp1); end
      seen = locked1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rate0_relock: got timeout want locked"); end
    repeat (2) @(negedge clk);
    prev_rise = rise1;
    repeat (40) begin
      @(negedge clk); total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL rate0_model: got %h want %h", obs1, exp1); end
      total++;
      if ((rise1 ^ fall1) !== 1'b1 || rise1 === prev_rise) begin
        bad++; $display("FAIL rate0_alternate: got rise=%b fall=%b prev_rise=%b", rise1, fall1, prev_rise);
      end
      prev_rise = rise1;
    end
  endtask

  task automatic test_rate_change;
    int r;
    bit seen;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) r = 2;
      else if (it == 1) r = 1;
      else begin
        do r = $urandom_range(0, 4); while (r == int'(rate1));
      end
      rate1 = 3'(r);
      @(negedge clk); total++;
      if (locked1 !== 1'b0) begin bad++; $display("FAIL change_unlock: got %b want 0", locked1); end
      seen = 0;
      for (int i = 0; i < 10000 && !seen; i++) begin
        @(negedge clk); total++;
        if (obs1 !== exp1) begin bad++; $display("FAIL change_model: got %h want %h", obs1, exp1); end
        seen = locked1;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL change_relock: got timeout want locked"); end
      repeat ($urandom_range(50, 400)) begin
        @(negedge clk); total++;
        if (obs1 !== exp1) begin bad++; $display("FAIL change_model: got %h want %h", obs1, exp1); end
      end
    end
  endtask

  task automatic test_clamp;
    bit seen;
    int c;
    rate1 = 3'd7;
    seen = 0;
    for (int i = 0; i < 10000 && !(seen && locked1); i++) begin
      @(negedge clk); total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL clamp_model: got %h want %h", obs1, exp1); end
      if (!locked1) seen = 1;
    end
    total++;
    if (!locked1) begin bad++; $display("FAIL clamp_relock: got timeout want locked"); end
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL clamp_model: got %h want %h", obs1, exp1); end
      seen = rise1;
    end
    c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); c++; total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL clamp_model: got %h want %h", obs1, exp1); end
      if (rise1) break;
    end
    total++;
    if (!seen || c != 64) begin bad++; $display("FAIL clamp_period: got %0d want 64", c); end
    for (int v = 5; v <= 6; v++) begin
      rate1 = 3'(v);
      repeat (150) begin
        @(negedge clk); total++;
        if (locked1 !== 1'b1 || obs1 !== exp1) begin
          bad++; $display("FAIL clamp_no_drain: got %h want %h (rate %0d)", obs1, exp1, v);
        end
      end
    end
  endtask

  task automatic test_dsd_mute;
    int n;
    bit seen;
    rst1 = 1'b1; rate1 = 3'd2; dsd1 = 1'b0;
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    repeat (3) begin
      @(negedge clk); total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL dsd_model: got %h want %h", obs1, exp1); end
    end
    dsd1 = 1'b1;
    n = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); n++; total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL dsd_model: got %h want %h", obs1, exp1); end
      if (locked1) begin seen = 1; break; end
    end
    total++;
    if (!seen || n != MC1 + 1) begin bad++; $display("FAIL dsd_mute_restart: got %0d want %0d", n, MC1 + 1); end
    repeat (600) begin
      @(negedge clk); total++;
      if (obs1 !== exp1 || slot1 !== 4'd0 || lrck1 !== 1'b0) begin
        bad++; $display("FAIL dsd_run: got %h want %h", obs1, exp1);
      end
    end
    dsd1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 2000 && !(seen && locked1); i++) begin
      @(negedge clk); total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL dsd_exit_model: got %h want %h", obs1, exp1); end
      if (!locked1) seen = 1;
    end
    total++;
    if (!locked1) begin bad++; $display("FAIL dsd_exit_relock: got timeout want locked"); end
  endtask

  task automatic test_rst_mid;
    repeat ($urandom_range(20, 300)) begin
      @(negedge clk); total++;
      if (obs1 !== exp1) begin bad++; $display("FAIL rstmid_model: got %h want %h", obs1, exp1); end
    end
    rst1 = 1'b1;
    @(negedge clk); total++;
    if (obs1 !== 15'd0) begin bad++; $display("FAIL rst_mid_frame: got %h want 0", obs1); end
    rst1 = 1'b0;
  endtask

  task automatic test_tdm;
    int n;
    bit seen;
    rst2 = 1'b1; rate2 = 3'd0; dsd2 = 1'b0;
    repeat (3) begin
      @(negedge clk); total++;
      if (obs2 !== 15'd0) begin bad++; $display("FAIL tdm_reset: got %h want 0", obs2); end
    end
    rst2 = 1'b0;
    n = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); n++;
      if (locked2) begin seen = 1; break; end
    end
    total++;
    if (!seen || n != MC2 + 1) begin bad++; $display("FAIL tdm_lock: got %0d want %0d", n, MC2 + 1); end
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      seen = (slot2 == 4'd4);
    end
    total++;
    if (!seen || bit2 !== 5'd0) begin bad++; $display("FAIL tdm_slot4: got slot=%0d bit=%0d want 4/0", slot2, bit2); end
    total++;
`ifdef SND_CLKGEN_I2S_DELAY_EN
    if (lrck2 !== 1'b0) begin bad++; $display("FAIL tdm_lrck_early: got %b want 0", lrck2); end
`else
    if (lrck2 !== 1'b1) begin bad++; $display("FAIL tdm_lrck_lj: got %b want 1", lrck2); end
`endif
    repeat (2) @(negedge clk);
    total++;
    if (lrck2 !== 1'b1 || bit2 !== 5'd1) begin
      bad++; $display("FAIL tdm_lrck_after: got lrck=%b bit=%0d want 1/1", lrck2, bit2);
    end
    repeat ($urandom_range(1, 15)) @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk); total++;
    if (obs2 !== 15'd0) begin bad++; $display("FAIL tdm_rst_mid: got %h want 0", obs2); end
  endtask

  initial begin
    test_reset();
    test_rate0();
    test_rate_change();
    test_clamp();
    test_dsd_mute();
    test_rst_mid();
    test_tdm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
